cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Parametrised multicycle control FSM for the 16-bit CPU. It sequences fetch, decode, execute, memory and write-back, and issues the PC, IR, register-file and data-memory strobes. It adds configurable memory wait states, per-class instruction sequencing (ALU / load / store / branch / jump / halt), a global stall and a halt state. It sits between the instruction decoder (instruction class, branch flag) and the datapath enables.

Parameters:
MEM_LATENCY, 0, extra wait cycles per memory access (instruction fetch and data); legal range 0..15
CLASS_W, 3, width of the instruction-class input
STATE_W, 4, width of the state_out debug bus

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
stall  input  1  freeze: state and wait counter hold, all strobes forced 0
instr_class  input  CLASS_W  from decoder, valid in DECODE: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 reserved
branch_taken  input  1  condition result, sampled in EXECUTE for BRANCH
pc_enable  output  1  PC increment strobe
pc_load  output  1  PC load-target strobe (branch/jump)
ir_enable  output  1  IR capture strobe
r_enable  output  1  register-file write strobe
rf_src_mem  output  1  register write-data select: 1 = memory, 0 = ALU
mem_addr_sel  output  1  memory address select: 1 = data address, 0 = PC
mem_we  output  1  data memory write strobe
halted  output  1  high while in HALT
state_out  output  STATE_W  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5. Other encodings are illegal and go to FETCH on the next clock.
- Outputs are Moore-style: they decode from the state and the wait counter only, so they change only after clk edges or reset.
- Reset asserted (low):
  - state=FETCH and wait counter=MEM_LATENCY, both immediately.
  - pc_enable, pc_load, r_enable, mem_we, rf_src_mem, halted = 0; mem_addr_sel=0.
  - ir_enable is 0 while reset is low.
- Release is synchronous to the next posedge. Reset mid-instruction aborts it with no further strobes.
- Wait counter:
  - Loaded with MEM_LATENCY on entry to FETCH and MEM; decrements each non-stalled cycle while non-zero.
  - A memory state exits only on a cycle where the counter is 0.
  - Each memory access therefore occupies MEM_LATENCY+1 cycles.
- FETCH:
  - mem_addr_sel=0.
  - ir_enable=1 only in the final cycle (counter=0), then go to DECODE.
- DECODE: no strobes. Next state by class:
  - ALU, BRANCH, JUMP, reserved -> EXECUTE
  - LOAD, STORE -> MEM
  - HALT -> HALT
- EXECUTE: one cycle, then FETCH.
  - ALU: r_enable=1, pc_enable=1.
  - BRANCH: pc_load=branch_taken, pc_enable=!branch_taken, r_enable=0.
  - JUMP: pc_load=1.
  - Reserved: pc_enable=1 only (NOP).
- Class latch: instr_class is captured into a register in DECODE. EXECUTE, MEM and WRITEBACK use the latched value, not the live input.
- MEM: mem_addr_sel=1 for all cycles.
  - STORE: mem_we=1 and pc_enable=1 in the final cycle only, then FETCH.
  - LOAD: final cycle goes to WRITEBACK.
- WRITEBACK (load only): r_enable=1, rf_src_mem=1, pc_enable=1, mem_addr_sel=1; then FETCH.
- HALT: halted=1, all strobes 0. Left only by reset.
- Strobe exclusivity: pc_enable and pc_load are never both 1. Every strobe is high for exactly one cycle per instruction.
- Stall:
  - Takes effect in the same cycle: outputs forced 0 combinationally; state and counter hold. mem_addr_sel and halted are not forced.
  - Deasserting stall resumes exactly where the FSM paused. A stall during the final memory cycle delays that cycle's strobes.
- Instruction cycle counts (M=MEM_LATENCY, no stall): ALU/BRANCH/JUMP 3+M, STORE 3+2M, LOAD 4+2M.

Decomposition:
- Shared package cpu_pkg: state encodings, instruction-class constants (CLASS_ALU..CLASS_HALT), STATE_W.
- One natural sub-module: mem_wait_counter (load, decrement-with-enable, zero flag, width $clog2(MEM_LATENCY+1), minimum 1).
- Output decode stays inside cpu_ctrl_fsm.

Test Plan:
- M=0, reset low 3 cycles then high, class=ALU: state sequence 0,1,2,0; ir_enable at cycle 1, r_enable and pc_enable at cycle 3, period 3.
- M=2, LOAD: FETCH 3 cycles (ir_enable only in the 3rd), DECODE, MEM 3 cycles (mem_addr_sel=1), WRITEBACK with r_enable=rf_src_mem=pc_enable=1; total 8 cycles.
- M=1, STORE: mem_we high exactly one cycle, coinciding with pc_enable, in the 2nd MEM cycle; r_enable never high.
- BRANCH with branch_taken=1, then =0: EXECUTE shows pc_load=1/pc_enable=0, then pc_load=0/pc_enable=1; never both high.
- Stall high 4 cycles in the middle of a FETCH wait (M=3): state_out and counter frozen, ir_enable=0 throughout; total FETCH stretched to 8 cycles.
- HALT class, then toggle stall and run 20 cycles: halted=1, strobes 0; reset pulse low mid-HALT returns FETCH with halted=0 immediately (async).

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_pkg: state encodings and instruction-class constants shared by the CPU control path.
package cpu_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXECUTE   = 4'd2,
    MEM       = 4'd3,
    WRITEBACK = 4'd4,
    HALT      = 4'd5
  } state_t;
  localparam int CLASS_ALU    = 0;
  localparam int CLASS_LOAD   = 1;
  localparam int CLASS_STORE  = 2;
  localparam int CLASS_BRANCH = 3;
  localparam int CLASS_JUMP   = 4;
  localparam int CLASS_HALT   = 5;
endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: decoder/stall inputs and datapath strobes between control FSM and datapath.
interface cpu_ctrl_fsm_if #(
  parameter int CLASS_W = 3,
  parameter int STATE_W = cpu_pkg::STATE_W
);
  logic               stall;
  logic [CLASS_W-1:0] instr_class;
  logic               branch_taken;
  logic               pc_enable;
  logic               pc_load;
  logic               ir_enable;
  logic               r_enable;
  logic               rf_src_mem;
  logic               mem_addr_sel;
  logic               mem_we;
  logic               halted;
  logic [STATE_W-1:0] state_out;
  modport master (
    input  stall, instr_class, branch_taken,
    output pc_enable, pc_load, ir_enable, r_enable, rf_src_mem, mem_addr_sel, mem_we, halted, state_out
  );
  modport slave (
    output stall, instr_class, branch_taken,
    input  pc_enable, pc_load, ir_enable, r_enable, rf_src_mem, mem_addr_sel, mem_we, halted, state_out
  );
endinterface

// File: rtl/cpu_ctrl_fsm_mem_wait_counter.sv
// mem_wait_counter: memory wait-state down-counter with load, enabled decrement and zero flag.
module mem_wait_counter #(
  parameter int MAX = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int W = MAX > 0 ? $clog2(MAX + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= W'(MAX);
    else if (load) cnt <= W'(MAX);
    else if (en && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle fetch/decode/execute/mem/writeback sequencer issuing datapath strobes.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int CLASS_W     = 3,
  parameter int STATE_W     = cpu_pkg::STATE_W
) (
  input logic           clk,
  input logic           reset,
  cpu_ctrl_fsm_if.master bus
);
  localparam logic [CLASS_W-1:0] C_ALU    = CLASS_W'(CLASS_ALU);
  localparam logic [CLASS_W-1:0] C_LOAD   = CLASS_W'(CLASS_LOAD);
  localparam logic [CLASS_W-1:0] C_STORE  = CLASS_W'(CLASS_STORE);
  localparam logic [CLASS_W-1:0] C_BRANCH = CLASS_W'(CLASS_BRANCH);
  localparam logic [CLASS_W-1:0] C_JUMP   = CLASS_W'(CLASS_JUMP);
  localparam logic [CLASS_W-1:0] C_HALT   = CLASS_W'(CLASS_HALT);
  state_t             state, nxt;
  logic [CLASS_W-1:0] cls;
  logic               run, zero, load, ex, st_done;
  assign run = !bus.stall;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = zero ? DECODE : FETCH;
      DECODE:  nxt = (bus.instr_class == C_LOAD || bus.instr_class == C_STORE) ? MEM :
                     bus.instr_class == C_HALT ? HALT : EXECUTE;
      MEM:     nxt = !zero ? MEM : cls == C_LOAD ? WRITEBACK : FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  // Counter reloads only on a real entry into a memory state, never while dwelling in it.
  assign load = run && nxt != state && (nxt == FETCH || nxt == MEM);
  mem_wait_counter #(.MAX(MEM_LATENCY)) u_wait (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .en   (run),
    .zero (zero)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      cls   <= '0;
    end else if (run) begin
      state <= nxt;
      if (state == DECODE) cls <= bus.instr_class;
    end
  assign ex      = run && state == EXECUTE;
  assign st_done = run && state == MEM && zero && cls == C_STORE;
  // Reset gates ir_enable because with zero latency FETCH already shows a finished counter.
  assign bus.ir_enable    = run && reset && state == FETCH && zero;
  assign bus.pc_load      = ex && (cls == C_BRANCH ? bus.branch_taken : cls == C_JUMP);
  assign bus.pc_enable    = (ex && (cls == C_ALU || cls > C_HALT || (cls == C_BRANCH && !bus.branch_taken))) ||
                            st_done || (run && state == WRITEBACK);
  assign bus.r_enable     = (ex && cls == C_ALU) || (run && state == WRITEBACK);
  assign bus.rf_src_mem   = run && state == WRITEBACK;
  assign bus.mem_we       = st_done;
  assign bus.mem_addr_sel = state == MEM || state == WRITEBACK;
  assign bus.halted       = state == HALT;
  assign bus.state_out    = STATE_W'(state);
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: four instances (MEM_LATENCY 0..3) checked cycle by cycle against per-instruction expected streams.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;
  localparam logic [7:0] PCE = 8'h80, PCL = 8'h40, IR = 8'h20, RE = 8'h10;
  localparam logic [7:0] SRC = 8'h08, ASEL = 8'h04, WE = 8'h02, HLT = 8'h01;
  logic       clk = 0, reset = 0, stall = 0, bt = 0;
  logic [2:0] cls = 0;
  logic [11:0] obs [4];
  logic [11:0] exp_q [4][$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_ctrl_fsm_if #(.CLASS_W(3), .STATE_W(4)) bus ();
    assign bus.stall        = stall;
    assign bus.instr_class  = cls;
    assign bus.branch_taken = bt;
    cpu_ctrl_fsm #(.MEM_LATENCY(g), .CLASS_W(3), .STATE_W(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
    );
    assign obs[g] = {bus.state_out, bus.pc_enable, bus.pc_load, bus.ir_enable, bus.r_enable,
                     bus.rf_src_mem, bus.mem_addr_sel, bus.mem_we, bus.halted};
  end
  task automatic check(string tag, logic [11:0] act, logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [11:0] ev(int st, logic [7:0] f);
    return {st[3:0], f};
  endfunction
  task automatic push_instr(int m, int c, logic b);
    for (int i = 0; i < m; i++) exp_q[m].push_back(ev(0, 8'h00));
    exp_q[m].push_back(ev(0, IR));
    exp_q[m].push_back(ev(1, 8'h00));
    case (c)
      0: exp_q[m].push_back(ev(2, PCE | RE));
      1: begin
        for (int i = 0; i <= m; i++) exp_q[m].push_back(ev(3, ASEL));
        exp_q[m].push_back(ev(4, RE | SRC | PCE | ASEL));
      end
      2: begin
        for (int i = 0; i < m; i++) exp_q[m].push_back(ev(3, ASEL));
        exp_q[m].push_back(ev(3, ASEL | WE | PCE));
      end
      3: exp_q[m].push_back(ev(2, b ? PCL : PCE));
      4: exp_q[m].push_back(ev(2, PCL));
      5: for (int i = 0; i < 40; i++) exp_q[m].push_back(ev(5, HLT));
      default: exp_q[m].push_back(ev(2, PCE));
    endcase
  endtask
  task automatic check_reset(string tag);
    for (int g = 0; g < 4; g++) check($sformatf("%s_m%0d", tag, g), obs[g], 12'h000);
  endtask
  task automatic run_phase(int c, logic b, int n, int s0, int sl, bit tog);
    logic [11:0] e;
    @(negedge clk);
    reset = 0;
    stall = 0;
    #1 check_reset($sformatf("rst_c%0d", c));
    repeat (2) begin
      @(negedge clk);
      #1 check_reset($sformatf("rst_hold_c%0d", c));
    end
    @(negedge clk);
    reset = 1;
    cls   = 3'(c);
    bt    = b;
    for (int g = 0; g < 4; g++) begin
      exp_q[g].delete();
      while (exp_q[g].size() < n + 1) push_instr(g, c, b);
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      stall = tog ? k[0] : (k >= s0 && k < s0 + sl);
      #1;
      for (int g = 0; g < 4; g++) begin
        e = stall ? exp_q[g][0] & 12'hF05 : exp_q[g][0];
        check($sformatf("c%0d_b%0d_m%0d_k%0d", c, b, g, k), obs[g], e);
        if (!stall) void'(exp_q[g].pop_front());
      end
    end
  endtask
  initial begin
    run_phase(0, 0, 12, 0, 0, 0);
    run_phase(1, 0, 20, 0, 0, 0);
    run_phase(2, 0, 16, 0, 0, 0);
    run_phase(3, 1, 10, 0, 0, 0);
    run_phase(3, 0, 10, 0, 0, 0);
    run_phase(4, 0, 10, 0, 0, 0);
    run_phase(7, 0, 10, 0, 0, 0);
    run_phase(0, 0, 16, 1, 4, 0);
    run_phase(1, 0, 24, 5, 3, 0);
    run_phase(5, 0, 20, 0, 0, 1);
    @(posedge clk);
    #2 reset = 0;
    #1 check_reset("async_halt_exit");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
